// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// ----------------
// Scans a 4-digit common-anode seven-segment display from a 16-bit hex value.
// The refresh (~1 kHz) and blink (~1 Hz) square waves from the clock divider
// are brought into the clk domain through synchronizer chains. Each rising
// edge of the refresh wave advances the digit index by one.
//
// The displayed value and the decimal points are latched into a shadow
// register only when the index wraps from 3 to 0. This keeps a frame from
// tearing when the value changes part-way through it.
//
// Ports:
//   clk         system clock (100 MHz)
//   reset       asynchronous, active-low reset
//   khz_in      refresh square wave, asynchronous
//   hz_in       blink square wave, asynchronous
//   value       hex value; digit0 = value[3:0] (rightmost)
//   dp_in       per-digit decimal point request, active-high
//   blink_mask  per-digit blink enable, active-high
//   an          anode enables, active-low, an[0] = rightmost digit
//   seg         cathodes, active-low, {g,f,e,d,c,b,a}
//   dp          decimal point cathode, active-low
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN  blanks leading zero digits (digit 0 always shown)

module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,  // only 4 is supported
  parameter int SYNC_STAGES = 2   // minimum 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        khz_in,
  input  logic        hz_in,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

  // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [SYNC_STAGES-1:0] khz_sync_r;
  logic [SYNC_STAGES-1:0] hz_sync_r;
  logic                   khz_prev_r;
  logic [1:0]             idx_r;
  logic [15:0]            shadow_r;
  logic [3:0]             shadow_dp_r;
  logic                   started_r;

  logic                   khz_s;
  logic                   hz_s;
  logic                   tick_s;
  logic [3:0]             nib_s;
  logic                   lz_blank_s;
  logic [3:0]             an_nxt_s;
  logic [6:0]             seg_nxt_s;
  logic                   dp_nxt_s;

  assign khz_s  = khz_sync_r[SYNC_STAGES-1];
  assign hz_s   = hz_sync_r[SYNC_STAGES-1];
  // A single-cycle pulse on each rising refresh edge. Falling edges give nothing.
  assign tick_s = khz_s & ~khz_prev_r;

  // Input synchronizer chains and the refresh edge-detect flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      khz_sync_r <= '0;
      hz_sync_r  <= '0;
      khz_prev_r <= 1'b0;
    end else begin
      khz_sync_r <= {khz_sync_r[SYNC_STAGES-2:0], khz_in};
      hz_sync_r  <= {hz_sync_r[SYNC_STAGES-2:0], hz_in};
      khz_prev_r <= khz_s;
    end
  end

  // Scan index, frame-wrap shadow load and the started flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r       <= 2'd0;
      shadow_r    <= 16'h0000;
      shadow_dp_r <= 4'h0;
      started_r   <= 1'b0;
    end else if (tick_s) begin
      started_r <= 1'b1;
      if (idx_r == LAST_IDX) begin
        idx_r       <= 2'd0;
        shadow_r    <= value;
        shadow_dp_r <= dp_in;
      end else begin
        idx_r <= idx_r + 2'd1;
      end
    end
  end

  // Select the shadow nibble for the current digit slot.
  always_comb begin
    nib_s = 4'h0;
    case (idx_r)
      2'd0:    nib_s = shadow_r[3:0];
      2'd1:    nib_s = shadow_r[7:4];
      2'd2:    nib_s = shadow_r[11:8];
      2'd3:    nib_s = shadow_r[15:12];
      default: nib_s = 4'h0;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz_blank_s = 1'b0;
    case (idx_r)
      2'd0:    lz_blank_s = 1'b0;
      2'd1:    lz_blank_s = (shadow_r[15:4] == 12'h000);
      2'd2:    lz_blank_s = (shadow_r[15:8] == 8'h00);
      2'd3:    lz_blank_s = (shadow_r[15:12] == 4'h0);
      default: lz_blank_s = 1'b0;
    endcase
  end
`else
  assign lz_blank_s = 1'b0;
`endif

  // Next output values: blank before the first tick, otherwise drive the current slot.
  always_comb begin
    an_nxt_s  = 4'hF;
    seg_nxt_s = 7'h7F;
    dp_nxt_s  = 1'b1;
    if (started_r) begin
      seg_nxt_s = seg_decode(nib_s);
      if (lz_blank_s) begin
        an_nxt_s = 4'hF;
        dp_nxt_s = 1'b1;
      end else begin
        dp_nxt_s = ~shadow_dp_r[idx_r];
        // The blink mask gates only the anode, so the scan timing is unchanged.
        if (blink_mask[idx_r] && !hz_s) begin
          an_nxt_s = 4'hF;
        end else begin
          an_nxt_s = ~(4'b0001 << idx_r);
        end
      end
    end else begin
      an_nxt_s  = 4'hF;
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt_s;
      seg <= seg_nxt_s;
      dp  <= dp_nxt_s;
    end
  end

endmodule
